// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the external memory bridge.
// The internal window limits are kept here so the address decoder and bridge agree.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RELEASE,
    DONE,
    ERR
  } state_t;

  localparam logic [31:0] INT_LO    = 32'h0000_0D40;
  localparam logic [31:0] INT_HI    = 32'h0000_113F;
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  function automatic logic in_int_window(input logic [31:0] addr);
    return (addr >= INT_LO) && (addr <= INT_HI);
  endfunction

endpackage

// File: rtl/ext_bus_timer.sv
// Saturating wait counter; expired is high once TIMEOUT-1 cycles have been counted.
// Latency: count visible the cycle after clr/en; expired is combinational from count.
// Backpressure: none, saturates at TIMEOUT-1 and holds until cleared.
module ext_bus_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ext_mem_bridge.sv
// Turns CPU loads/stores outside the internal window into four-phase req/ack bus cycles.
// Latency: with a one-cycle responder, Stall is high 5 cycles and drops in the DONE cycle.
// Backpressure: Stall holds the pipeline until the handshake completes or times out.
module ext_mem_bridge
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] Address,
  input  logic              CS,
  input  logic              RE,
  input  logic              WE,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              BusErr,
  output logic [ADDR_W-1:0] ExtAddr,
  output logic [DATA_W-1:0] ExtWData,
  output logic              ExtWE,
  output logic              ExtReq,
  input  logic              ExtAck,
  input  logic [DATA_W-1:0] ExtRData
);

  state_t state, next_state;
  logic   accept;
  logic   stall_fsm;
  logic   tmr_clr, tmr_en, tmr_exp;

  assign accept = CS & (RE | WE);

  always_comb begin
    next_state = state;
    stall_fsm  = 1'b0;
    ExtReq     = 1'b0;
    BusErr     = 1'b0;
    case (state)
      IDLE: begin
        // A stale ack from a previous cycle must clear before a new request starts.
        stall_fsm = accept;
        if (accept && !ExtAck) next_state = REQ;
      end
      REQ: begin
        ExtReq    = 1'b1;
        stall_fsm = 1'b1;
        if (ExtAck)       next_state = RELEASE;
        else if (tmr_exp) next_state = ERR;
      end
      RELEASE: begin
        stall_fsm = 1'b1;
        if (!ExtAck)      next_state = DONE;
        else if (tmr_exp) next_state = ERR;
      end
      DONE: begin
        next_state = IDLE;
      end
      ERR: begin
        BusErr     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Held-low reset releases the pipeline even if the CPU keeps its request up.
  assign Stall = RST & stall_fsm;

  assign tmr_en  = (state == REQ) || (state == RELEASE);
  assign tmr_clr = (next_state != state) &&
                   ((next_state == REQ) || (next_state == RELEASE));

  ext_bus_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (CLK),
    .rst_n  (RST),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_exp)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      ExtAddr  <= '0;
      ExtWData <= '0;
      ExtWE    <= 1'b0;
      ReadData <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == REQ) begin
        ExtAddr  <= Address;
        ExtWData <= WriteData;
        ExtWE    <= WE;
      end
      if (state == REQ && next_state == RELEASE && !ExtWE) begin
        ReadData <= ExtRData;
      end
      if (next_state == ERR) begin
        ReadData <= DATA_W'(ERR_RDATA);
      end
    end
  end

endmodule
